write_ctrl: RTL and testbench

WRITE_CTRL -- requirements
Module: write_ctrl

---
 rtl/write_ctrl.sv | 105 ++++++++++
 tb/tb_write_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_ctrl.sv
// rtl/write_ctrl.sv - ping-pong RAM write controller with per-slot full tracking
// Optional WR_STICKY_ERR_EN: hold error high from a rejected write until the next accepted write.
module write_ctrl #(
   parameter int   SIZE = 8,
   parameter logic PUSH = 1'b1
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic [SIZE-1:0] din,
   input  logic            write,
   input  logic [1:0]      r_done,
   output logic [SIZE-1:0] w_data,
   output logic            w_addr,
   output logic            w_en,
   output logic [1:0]      status_vld,
   output logic            busy,
   output logic            error
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [SIZE-1:0] w_data_nxt;
   logic            w_addr_nxt;
   logic            w_en_nxt;
   logic [1:0]      status_vld_nxt;
   logic            error_nxt;
   logic [1:0]      r_done_q;
   logic [1:0]      r_done_rise;
   logic [1:0]      set_mask;
   logic            push;

   assign push        = (write == PUSH);
   assign r_done_rise = r_done & ~r_done_q;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         w_data     <= '0;
         w_addr     <= 1'b0;
         w_en       <= 1'b0;
         status_vld <= 2'b00;
         error      <= 1'b0;
         r_done_q   <= 2'b00;
      end else begin
         state      <= state_nxt;
         w_data     <= w_data_nxt;
         w_addr     <= w_addr_nxt;
         w_en       <= w_en_nxt;
         status_vld <= status_vld_nxt;
         error      <= error_nxt;
         r_done_q   <= r_done;
      end
   end

   always_comb begin
      state_nxt  = state;
      w_data_nxt = w_data;
      w_addr_nxt = w_addr;
      w_en_nxt   = 1'b0;
      set_mask   = 2'b00;
`ifdef WR_STICKY_ERR_EN
      error_nxt  = error;
`else
      error_nxt  = 1'b0;
`endif

      case (state)
         IDLE: begin
            // The full flag is sampled before this edge's clear, so a read
            // finishing on the same edge still rejects the write.
            if (push) begin
               if (status_vld[w_addr]) begin
                  error_nxt = 1'b1;
               end else begin
                  w_data_nxt = din;
                  w_en_nxt   = 1'b1;
                  error_nxt  = 1'b0;
                  state_nxt  = WRITE;
               end
            end
         end
         WRITE: begin
            state_nxt = DONE;
         end
         DONE: begin
            set_mask[w_addr] = 1'b1;
            w_addr_nxt       = ~w_addr;
            state_nxt        = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Set is applied after clear so it wins on a shared edge.
      status_vld_nxt = (status_vld & ~r_done_rise) | set_mask;
   end

endmodule

// File: tb/tb_write_ctrl.sv
// tb/tb_write_ctrl.sv - randomized self-checking bench for write_ctrl against a slot-occupancy model
module tb_write_ctrl;
   localparam int SIZE = 8;

   logic            clk = 1'b0;
   logic            n_rst = 1'b0;
   logic [SIZE-1:0] din = '0;
   logic            write = 1'b0;
   logic [1:0]      r_done = 2'b00;
   logic [SIZE-1:0] w_data;
   logic            w_addr;
   logic            w_en;
   logic [1:0]      status_vld;
   logic            busy;
   logic            error;

   int checks = 0;
   int failures = 0;

   // Reference: which slots hold unread data, where the next write goes,
   // and how many edges have elapsed since the last accepted write.
   logic [1:0]      m_full;
   logic            m_ptr;
   logic            m_inflight;
   int              m_age;
   logic [SIZE-1:0] m_data;
   logic            m_wen;
   logic            m_err;
   logic [1:0]      m_rd_prev;

   write_ctrl #(.SIZE(SIZE), .PUSH(1'b1)) dut (
      .clk(clk), .n_rst(n_rst), .din(din), .write(write), .r_done(r_done),
      .w_data(w_data), .w_addr(w_addr), .w_en(w_en), .status_vld(status_vld),
      .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_full = 2'b00; m_ptr = 1'b0; m_inflight = 1'b0; m_age = 0;
      m_data = '0; m_wen = 1'b0; m_err = 1'b0; m_rd_prev = 2'b00;
   endtask

   task automatic model_edge();
      logic       acc, rej;
      logic [1:0] rise, setm;
      rise = r_done & ~m_rd_prev;
      m_rd_prev = r_done;
      setm = 2'b00;
      acc = !m_inflight && write && !m_full[m_ptr];
      rej = !m_inflight && write && m_full[m_ptr];
      if (m_inflight) begin
         if (m_age == 1) begin
            setm[m_ptr] = 1'b1;
            m_ptr = ~m_ptr;
            m_inflight = 1'b0;
         end else begin
            m_age++;
         end
      end
      if (acc) begin
         m_inflight = 1'b1;
         m_age = 0;
         m_data = din;
      end
      m_full = (m_full & ~rise) | setm;
      m_wen = acc;
`ifdef WR_STICKY_ERR_EN
      m_err = (m_err | rej) & ~acc;
`else
      m_err = rej;
`endif
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".w_en"}, 32'(w_en), 32'(m_wen));
      check({tag, ".w_addr"}, 32'(w_addr), 32'(m_ptr));
      check({tag, ".w_data"}, 32'(w_data), 32'(m_data));
      check({tag, ".status_vld"}, 32'(status_vld), 32'(m_full));
      check({tag, ".busy"}, 32'(busy), 32'(m_inflight));
      check({tag, ".error"}, 32'(error), 32'(m_err));
   endtask

   // Inputs change only just after a falling edge; outputs are checked 1 time unit after the rising edge.
   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
      @(negedge clk);
      write = 1'b0;
   endtask

   task automatic press(input logic [SIZE-1:0] d, input string tag);
      din = d;
      write = 1'b1;
      tick(tag);
   endtask

   task automatic do_reset(input string tag);
      n_rst = 1'b0;
      write = 1'b0;
      r_done = 2'b00;
      #1;
      model_reset();
      compare_all(tag);
      n_rst = 1'b1;
   endtask

   initial begin
      model_reset();
      #3;
      check("por.w_en", 32'(w_en), 0);
      check("por.status_vld", 32'(status_vld), 0);
      check("por.busy", 32'(busy), 0);
      check("por.error", 32'(error), 0);
      @(negedge clk);
      do_reset("rst0");

      // First edge after release accepts; slot 0 fills two edges later.
      press(8'hA5, "a5");
      check("a5.w_en", 32'(w_en), 1);
      check("a5.w_addr", 32'(w_addr), 0);
      check("a5.w_data", 32'(w_data), 32'h A5);
      tick("a5.t1");
      tick("a5.t2");
      check("a5.status", 32'(status_vld), 32'h1);
      check("a5.w_addr_next", 32'(w_addr), 1);
      check("a5.busy", 32'(busy), 0);

      // Both slots full, third write rejected.
      do_reset("rst1");
      press(8'h11, "w11"); tick("w11.t1"); tick("w11.t2");
      press(8'h22, "w22"); tick("w22.t1"); tick("w22.t2");
      check("full.status", 32'(status_vld), 32'h3);
      press(8'h33, "rej");
      check("rej.error", 32'(error), 1);
      check("rej.w_en", 32'(w_en), 0);
      check("rej.w_data", 32'(w_data), 32'h22);
      tick("rej.t1");
`ifdef WR_STICKY_ERR_EN
      check("rej.error_held", 32'(error), 1);
`else
      check("rej.error_pulse", 32'(error), 0);
`endif

      // Read-done edge frees slot 0 once; the held level must not clear it again.
      r_done = 2'b01;
      tick("rd.rise");
      check("rd.status", 32'(status_vld), 32'h2);
      for (int i = 0; i < 9; i++) tick("rd.hold");
      press(8'h33, "w33");
      check("w33.w_en", 32'(w_en), 1);
      check("w33.w_addr", 32'(w_addr), 0);
      tick("w33.t1"); tick("w33.t2");
      check("w33.status", 32'(status_vld), 32'h3);
      check("w33.error", 32'(error), 0);

      // Write while busy is ignored.
      do_reset("rst2");
      press(8'h44, "w44");
      press(8'h55, "busy_w");
      check("busy_w.w_en", 32'(w_en), 0);
      check("busy_w.error", 32'(error), 0);
      check("busy_w.w_data", 32'(w_data), 32'h44);
      tick("busy_w.t2");
      tick("busy_w.t3");
      check("busy_w.status", 32'(status_vld), 32'h1);

      // Asynchronous reset while w_en is high.
      do_reset("rst3");
      press(8'h66, "w66");
      check("w66.w_en", 32'(w_en), 1);
      n_rst = 1'b0;
      #1;
      check("arst.w_en", 32'(w_en), 0);
      check("arst.w_data", 32'(w_data), 0);
      check("arst.w_addr", 32'(w_addr), 0);
      check("arst.busy", 32'(busy), 0);
      do_reset("arst");
      press(8'h77, "w77");
      check("w77.w_addr", 32'(w_addr), 0);
      tick("w77.t1"); tick("w77.t2");
      check("w77.status", 32'(status_vld), 32'h1);

      // Write on the same edge as the slot's read-done rise is rejected.
      do_reset("rst4");
      press(8'h01, "f0"); tick("f0.t1"); tick("f0.t2");
      press(8'h02, "f1"); tick("f1.t1"); tick("f1.t2");
      r_done = 2'b01;
      press(8'h88, "race");
      check("race.error", 32'(error), 1);
      check("race.w_en", 32'(w_en), 0);
      check("race.status", 32'(status_vld), 32'h2);
      press(8'h99, "retry");
      check("retry.w_en", 32'(w_en), 1);
      check("retry.w_data", 32'(w_data), 32'h99);

      // Set and clear of the same bit on one edge: set wins.
      do_reset("rst5");
      press(8'h12, "sc"); tick("sc.t1");
      r_done = 2'b01;
      tick("sc.t2");
      check("sc.status", 32'(status_vld), 32'h1);

      // Random traffic.
      do_reset("rst6");
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) do_reset("rnd.rst");
         din = SIZE'($urandom);
         write = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) r_done[0] = ~r_done[0];
         if ($urandom_range(0, 7) == 0) r_done[1] = ~r_done[1];
         tick("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
